// File: rtl/wght_seq_ctrl.sv
// Weight RAM sequencer: loads K*K*L words as one contiguous burst, waits for
// write-complete, then replays the L kernel-bank reads once per pass.
module wght_seq_ctrl #(
   parameter int W      = 8,
   parameter int K      = 5,
   parameter int L      = 6,
   parameter int RD_LAT = 2,
   parameter int TMO    = 256
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_go,
   input  logic [7:0]           cfg_npass,
   input  logic                 src_valid,
   input  logic [W-1:0]         src_data,
   output logic                 src_ready,
   output logic                 ram_we,
   output logic [W-1:0]         ram_data,
   input  logic                 ram_write_complete,
   output logic                 ram_start,
   input  logic                 conv_ready,
   output logic                 bank_valid,
   output logic [$clog2(L)-1:0] bank_idx,
   output logic                 busy,
   output logic                 done,
   output logic                 err_underrun,
   output logic                 err_timeout
);

   localparam int NB = K*K*L;
   localparam int BW = $clog2(NB+1);
   localparam int TW = $clog2(TMO+1);
   localparam int RW = $clog2(RD_LAT+L+1);
   localparam int IW = $clog2(L);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD   = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_ARM    = 3'd3;
   localparam logic [2:0] S_READ   = 3'd4;
   localparam logic [2:0] S_FINISH = 3'd5;

   // Reset asserts asynchronously but releases only after two clk edges.
   logic [1:0] rsync_q, rsync_d;
   logic       rst_n_i;

   always_comb rsync_d = {rsync_q[0], 1'b1};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rsync_q <= 2'b00;
      else      rsync_q <= rsync_d;
   end

   assign rst_n_i = rsync_q[1];

   logic [2:0]    state_q, state_d;
   logic [BW-1:0] beat_q, beat_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [RW-1:0] rd_q, rd_d;
   logic [7:0]    pass_q, pass_d;
   logic [7:0]    npass_q, npass_d;
   logic          we_q, we_d;
   logic [W-1:0]  data_q, data_d;
   logic          eu_q, eu_d;
   logic          et_q, et_d;

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      tmo_d   = tmo_q;
      rd_d    = rd_q;
      pass_d  = pass_q;
      npass_d = npass_q;
      we_d    = 1'b0;
      data_d  = data_q;
      eu_d    = eu_q;
      et_d    = et_q;
      case (state_q)
         S_IDLE: begin
            if (cfg_go) begin
               npass_d = (cfg_npass == 8'd0) ? 8'd1 : cfg_npass;
               eu_d    = 1'b0;
               et_d    = 1'b0;
               beat_d  = '0;
               pass_d  = '0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (src_valid) begin
               we_d   = 1'b1;
               data_d = src_data;
               if (beat_q == BW'(NB-1)) begin
                  beat_d  = '0;
                  tmo_d   = '0;
                  state_d = S_WAIT;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end else if (beat_q != '0) begin
               // The RAM address already moved on; only a fresh burst is safe.
               eu_d   = 1'b1;
               beat_d = '0;
            end
         end
         S_WAIT: begin
            if (ram_write_complete) begin
               state_d = S_ARM;
            end else if (tmo_q == TW'(TMO-1)) begin
               et_d    = 1'b1;
               state_d = S_FINISH;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         S_ARM: begin
            rd_d = '0;
            if (conv_ready) state_d = S_READ;
         end
         S_READ: begin
            if (rd_q == RW'(RD_LAT+L-1)) begin
               rd_d   = '0;
               pass_d = pass_q + 1'b1;
               if (pass_q == npass_q - 8'd1) state_d = S_FINISH;
               else                          state_d = S_ARM;
            end else begin
               rd_d = rd_q + 1'b1;
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= S_IDLE;
         beat_q  <= '0;
         tmo_q   <= '0;
         rd_q    <= '0;
         pass_q  <= '0;
         npass_q <= '0;
         we_q    <= 1'b0;
         data_q  <= '0;
         eu_q    <= 1'b0;
         et_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         tmo_q   <= tmo_d;
         rd_q    <= rd_d;
         pass_q  <= pass_d;
         npass_q <= npass_d;
         we_q    <= we_d;
         data_q  <= data_d;
         eu_q    <= eu_d;
         et_q    <= et_d;
      end
   end

   logic [RW-1:0] rd_off;

   assign rd_off       = rd_q - RW'(RD_LAT);
   assign src_ready    = (state_q == S_LOAD);
   assign ram_we       = we_q;
   assign ram_data     = data_q;
   assign ram_start    = (state_q == S_READ);
   assign bank_valid   = (state_q == S_READ) && (rd_q >= RW'(RD_LAT));
   assign bank_idx     = bank_valid ? rd_off[IW-1:0] : '0;
   assign busy         = (state_q != S_IDLE);
   assign done         = (state_q == S_FINISH);
   assign err_underrun = eu_q;
   assign err_timeout  = et_q;

endmodule

// File: doc/wght_seq_ctrl.md
Name: wght_seq_ctrl

Overview:
Sequencing controller for the convolution weight RAM.
- On a go pulse it streams K*K*L weight words from an upstream source into the RAM write port as one unbroken burst.
- It waits for the RAM's write-complete flag, then replays the L kernel-bank reads once per requested pass, in step with the conv engine's ready signal.
- It sits between the weight source, the weight RAM and the conv datapath. It is the only driver of the RAM's we/data/start inputs.

Parameters:
W, 8, weight word width (matches RAM w)
K, 5, kernel dimension; one bank = K*K words
L, 6, number of kernel banks in RAM
RD_LAT, 2, cycles from ram_start rising to first valid weight_bank at RAM output
TMO, 256, write-complete timeout in cycles

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
cfg_go  in  1  1-cycle pulse: begin load + compute job
cfg_npass  in  8  read passes per job, sampled on cfg_go; 0 treated as 1
src_valid  in  1  upstream weight word valid
src_data  in  W  upstream weight word
src_ready  out  1  controller accepting weight words
ram_we  out  1  RAM write enable
ram_data  out  W  RAM write data
ram_write_complete  in  1  RAM write-complete flag
ram_start  out  1  RAM read enable (level)
conv_ready  in  1  conv engine can take a full L-bank burst
bank_valid  out  1  RAM weight_bank output holds a valid bank this cycle
bank_idx  out  $clog2(L)  index of the bank currently presented
busy  out  1  job in progress
done  out  1  1-cycle pulse at job end
err_underrun  out  1  sticky: load restarted due to src_valid gap; cleared on cfg_go
err_timeout  out  1  sticky: write_complete not seen within TMO; cleared on cfg_go

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; beat, pass and timeout counters 0.
- Deassertion of rst is synchronised to clk with a 2-flop synchroniser.
- States: IDLE, LOAD, WAIT_WC, ARM, READ, FINISH.
- IDLE:
  - busy=0.
  - cfg_go=1 latches npass (0→1), clears both err flags and moves to LOAD.
  - cfg_go in any other state is ignored.
- LOAD:
  - src_ready=1 and busy=1.
  - Each cycle with src_valid=1: ram_we=1 and ram_data=src_data, both registered, 1-cycle latency.
  - The beat counter increments on each such cycle.
  - The burst must be contiguous, because the RAM address advances every clock.
  - If src_valid=0 while 0<beats<K*K*L: set err_underrun, hold ram_we=0 for one cycle, reset the beat counter to 0 and remain in LOAD. The next we rising edge restarts RAM addressing.
  - src_valid=0 with beats=0 is a legal wait.
  - After beat K*K*L is accepted: src_ready drops the same cycle, ram_we drops the following cycle, and the state moves to WAIT_WC.
- WAIT_WC:
  - The timeout counter runs.
  - ram_write_complete=1 → ARM.
  - Counter reaching TMO → set err_timeout and go to FINISH (done still pulses).
- ARM:
  - ram_start=0 for at least 1 cycle, which guarantees a start rising edge at the RAM.
  - Leave for READ only when conv_ready=1.
- READ:
  - ram_start=1 for exactly RD_LAT+L cycles; it cannot stall.
  - bank_valid=1 from cycle RD_LAT through RD_LAT+L-1 after entry.
  - bank_idx counts 0..L-1, one per cycle, while bank_valid=1; otherwise it is 0.
  - conv_ready is sampled only on ARM→READ. The conv engine must accept all L banks consecutively.
  - At the end of READ: pass counter +1. If pass<npass → ARM (start drops ≥1 cycle); else → FINISH.
- FINISH: done=1 for one cycle, busy=0 next cycle, return to IDLE.
- Mid-job rst: immediate abort to IDLE, outputs 0, no done pulse.
- Counter widths:
  - beat counter holds K*K*L.
  - timeout counter holds TMO.
  - pass counter is 8 bit.
  - No wrap-around is permitted.

Test Plan:
- Nominal job, defaults, npass=1: go, 150 contiguous beats with data=i → ram_we high for exactly 150 cycles, ram_data=0..149 in order; write_complete asserted 10 cycles later; conv_ready=1 → ram_start high 8 cycles, bank_valid high 6 cycles with bank_idx 0..5, done pulses once, err flags 0.
- Underrun: src_valid drops at beat 40 for 3 cycles, then 150 contiguous beats → err_underrun=1, ram_we gap ≥1 cycle, total we-high cycles after restart =150, job completes with done.
- Timeout: ram_write_complete held 0 → err_timeout=1 exactly 256 cycles after WAIT_WC entry, done pulses, no ram_start ever asserted.
- Multi-pass with backpressure: npass=3, conv_ready low 5 cycles before pass 2 → three separate ram_start bursts of 8 cycles each, each separated by ≥1 low cycle, 18 total bank_valid cycles, a single done.
- npass=0 and cfg_go while busy: npass=0 behaves as 1 pass; a second cfg_go mid-LOAD has no effect on counters or flags.
- Async reset mid-READ: rst=0 between clock edges → all outputs 0 immediately; after release a fresh go runs a full nominal job correctly.
